muldiv_sequencer: RTL and testbench

- Multi-cycle sequencer for the MULT and DIV operations decoded by the instruction controller.
- The single-cycle ALU cannot complete these operations in one cycle. This block accepts a request, runs an iterative shift-add multiply or a restoring divide over WIDTH cycles, and writes the HI/LO result registers.
- Its busy output stalls PC/fetch in the core for the duration of the operation.

---
 rtl/muldiv_sequencer_if.sv | 30 +++
 rtl/muldiv_sequencer.sv | 160 ++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_sequencer_if.sv
// Request/response bundle between the instruction controller and the
// MULT/DIV sequencer.
//   master : start, op_div, op_signed, operand_a, operand_b, cancel (out)
//            hi, lo, busy, done, div_by_zero                       (in)
//   slave  : mirror image of master
interface muldiv_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic             op_div;
  logic             op_signed;
  logic [WIDTH-1:0] operand_a;
  logic [WIDTH-1:0] operand_b;
  logic             cancel;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, op_div, op_signed, operand_a, operand_b, cancel,
    input  hi, lo, busy, done, div_by_zero
  );

  modport slave (
    input  start, op_div, op_signed, operand_a, operand_b, cancel,
    output hi, lo, busy, done, div_by_zero
  );
endinterface

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/DIV sequencer: iterative shift-add multiply or restoring
// divide over WIDTH cycles, then one sign-fix cycle writing HI/LO.
// Ports:
//   clk, rst_n : core clock, asynchronous active-low reset
//   bus        : muldiv_sequencer_if.slave (request in, HI/LO/busy/done out)
// Optional feature: define SIGNED_MULDIV_EN to honour op_signed; otherwise
// every operation is unsigned and FIX passes results through unchanged.
module muldiv_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  muldiv_sequencer_if.slave   bus
);
  localparam int unsigned W  = WIDTH;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic            r_op_div;
  logic            r_neg_res;  // quotient / product must be negated
  logic            r_neg_rem;  // remainder takes dividend's sign
  logic [W-1:0]    r_acc_hi;   // mult: upper accumulator; div: remainder
  logic [W-1:0]    r_acc_lo;   // mult: multiplier shifting out; div: dividend -> quotient
  logic [W-1:0]    r_opb;      // mult: multiplicand; div: divisor
  logic [W-1:0]    r_hi;
  logic [W-1:0]    r_lo;
  logic            r_done;
  logic            r_dbz;

  // Sign handling of the request operands
  logic            w_signed;
`ifdef SIGNED_MULDIV_EN
  assign w_signed = bus.op_signed;
`else
  logic            w_unused_signed;
  assign w_signed        = 1'b0;
  assign w_unused_signed = bus.op_signed;
`endif

  logic            w_a_neg, w_b_neg;
  logic [W-1:0]    w_a_mag, w_b_mag;
  assign w_a_neg = w_signed & bus.operand_a[W-1];
  assign w_b_neg = w_signed & bus.operand_b[W-1];
  assign w_a_mag = w_a_neg ? -bus.operand_a : bus.operand_a;
  assign w_b_mag = w_b_neg ? -bus.operand_b : bus.operand_b;

  // Multiply step: conditional add into the upper half, carry kept for the shift
  logic [W:0]      w_sum;
  assign w_sum = {1'b0, r_acc_hi} + (r_acc_lo[0] ? {1'b0, r_opb} : {(W+1){1'b0}});

  // Divide step: shift in next dividend bit, trial-subtract the divisor
  logic [W:0]      w_shift;
  logic            w_ge;
  logic [W-1:0]    w_sub;
  assign w_shift = {r_acc_hi, r_acc_lo[W-1]};
  assign w_ge    = (w_shift >= {1'b0, r_opb});
  assign w_sub   = W'(w_shift - {1'b0, r_opb});

  // Sign correction applied in FIX
  logic [2*W-1:0]  w_prod, w_prod_fix;
  logic [W-1:0]    w_quo_fix, w_rem_fix;
  assign w_prod     = {r_acc_hi, r_acc_lo};
  assign w_prod_fix = r_neg_res ? -w_prod : w_prod;
  assign w_quo_fix  = r_neg_res ? -r_acc_lo : r_acc_lo;
  assign w_rem_fix  = r_neg_rem ? -r_acc_hi : r_acc_hi;

  // Sequencer state, datapath and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_op_div  <= 1'b0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_acc_hi  <= '0;
      r_acc_lo  <= '0;
      r_opb     <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_done    <= 1'b0;
      r_dbz     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_dbz  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // start takes priority over a coincident cancel
          if (bus.start) begin
            r_op_div <= bus.op_div;
            r_cnt    <= '0;
            if (bus.op_div && (bus.operand_b == '0)) begin
              r_hi      <= bus.operand_a;
              r_lo      <= '1;
              r_neg_res <= 1'b0;
              r_neg_rem <= 1'b0;
              r_done    <= 1'b1;
              r_dbz     <= 1'b1;
              r_state   <= S_DONE;
            end else begin
              r_neg_res <= w_a_neg ^ w_b_neg;
              r_neg_rem <= w_a_neg;
              r_acc_hi  <= '0;
              r_opb     <= bus.op_div ? w_b_mag : w_a_mag;
              r_acc_lo  <= bus.op_div ? w_a_mag : w_b_mag;
              r_state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else begin
            if (r_op_div) begin
              r_acc_hi <= w_ge ? w_sub : w_shift[W-1:0];
              r_acc_lo <= {r_acc_lo[W-2:0], w_ge};
            end else begin
              r_acc_hi <= w_sum[W:1];
              r_acc_lo <= {w_sum[0], r_acc_lo[W-1:1]};
            end
            r_cnt <= r_cnt + CW'(1);
            if (r_cnt == CW'(W - 1)) begin
              r_state <= S_FIX;
            end
          end
        end
        S_FIX: begin
          if (bus.cancel) begin
            r_state <= S_IDLE;
          end else begin
            if (r_op_div) begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end else begin
              r_hi <= w_prod_fix[2*W-1:W];
              r_lo <= w_prod_fix[W-1:0];
            end
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.hi          = r_hi;
  assign bus.lo          = r_lo;
  assign bus.done        = r_done;
  assign bus.div_by_zero = r_dbz;
  assign bus.busy        = (r_state != S_IDLE);

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Randomized scoreboard bench for muldiv_sequencer: a driver issues requests
// and queues the expected HI/LO from an arithmetic reference model; a monitor
// pops and compares on every done pulse.
module tb_muldiv_sequencer;
  localparam int unsigned W = 32;
`ifdef SIGNED_MULDIV_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   n_done;
  logic [W-1:0] last_hi, last_lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
    int           lat;
    int           issue;
  } exp_t;
  exp_t exp_q[$];

  muldiv_sequencer_if #(.WIDTH(W)) bus ();

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h required 0x%08h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: plain wide arithmetic on sign/zero-extended operands
  function automatic void model(input logic div, input logic sgn,
                                input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] hi, output logic [W-1:0] lo,
                                output logic dbz);
    logic signed [2*W-1:0] sa, sb, r, q, m;
    logic s;
    s   = sgn & SIGNED_EN;
    dbz = 1'b0;
    if (div && (b == '0)) begin
      hi  = a;
      lo  = '1;
      dbz = 1'b1;
      return;
    end
    sa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    sb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    if (!div) begin
      r  = sa * sb;
      hi = r[2*W-1:W];
      lo = r[W-1:0];
    end else begin
      q  = sa / sb;
      m  = sa % sb;
      hi = m[W-1:0];
      lo = q[W-1:0];
    end
  endfunction

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      n_done++;
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_done: got done=1 required 0 (t=%0t)", $time);
      end else begin
        e = exp_q.pop_front();
        check("hi", bus.hi, e.hi);
        check("lo", bus.lo, e.lo);
        check("div_by_zero", W'(bus.div_by_zero), W'(e.dbz));
        check("done_latency", W'(cyc - e.issue), W'(e.lat));
        check("busy_with_done", W'(bus.busy), W'(1));
        last_hi = bus.hi;
        last_lo = bus.lo;
      end
    end
  end

  task automatic issue(input logic div, input logic sgn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input bit with_cancel);
    exp_t e;
    int t;
    @(negedge clk);
    t = 0;
    while (bus.busy && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (bus.busy) begin
      n_checks++;
      n_errors++;
      $display("FAIL issue_wait: got busy=1 required 0");
      return;
    end
    bus.start     = 1'b1;
    bus.op_div    = div;
    bus.op_signed = sgn;
    bus.operand_a = a;
    bus.operand_b = b;
    bus.cancel    = with_cancel;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.cancel = 1'b0;
    model(div, sgn, a, b, e.hi, e.lo, e.dbz);
    e.lat   = e.dbz ? 0 : int'(W) + 1;
    e.issue = cyc;
    exp_q.push_back(e);
  endtask

  // Counts cycles with busy high after the accept edge, bounded
  task automatic count_busy(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.busy) return;
      n++;
    end
    n_checks++;
    n_errors++;
    $display("FAIL busy_timeout: got busy=1 required 0");
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return {1'b1, {(W-1){1'b0}}};
      4:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int done_before;
    logic [W-1:0] prev_hi, prev_lo;
    n_checks = 0; n_errors = 0; n_done = 0; cyc = 0;
    last_hi = '0; last_lo = '0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.op_div = 1'b0; bus.op_signed = 1'b0;
    bus.operand_a = '0; bus.operand_b = '0; bus.cancel = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_hi", bus.hi, '0);
    check("reset_lo", bus.lo, '0);
    check("reset_busy", W'(bus.busy), '0);
    check("reset_done", W'(bus.done), '0);
    check("reset_dbz", W'(bus.div_by_zero), '0);
    rst_n = 1'b1;

    // Unsigned multiply with busy duration
    issue(1'b0, 1'b0, 32'h0000_FFFF, 32'h0001_0001, 1'b0);
    count_busy(n);
    check("mul_busy_cycles", W'(n), W'(W + 2));
    check("mul_const_hi", last_hi, 32'h0000_0000);
    check("mul_const_lo", last_lo, 32'hFFFF_FFFF);

    // Unsigned divide
    issue(1'b1, 1'b0, 32'd100, 32'd7, 1'b0);
    count_busy(n);
    check("div_const_hi", last_hi, 32'd2);
    check("div_const_lo", last_lo, 32'd14);

    // Signed multiply / divide / overflow
    issue(1'b0, 1'b1, 32'hFFFF_FFFD, 32'd5, 1'b0);
    count_busy(n);
    check("smul_const_hi", last_hi, SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0004);
    check("smul_const_lo", last_lo, 32'hFFFF_FFF1);
    issue(1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0);
    count_busy(n);
    check("sdiv_const_hi", last_hi, SIGNED_EN ? 32'hFFFF_FFFF : 32'h0000_0001);
    check("sdiv_const_lo", last_lo, SIGNED_EN ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
    issue(1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    count_busy(n);

    // Divide by zero, with a coincident cancel that start must override
    issue(1'b1, 1'b1, 32'h0000_1234, 32'h0, 1'b1);
    count_busy(n);
    check("dbz_busy_cycles", W'(n), W'(1));
    check("dbz_const_hi", last_hi, 32'h0000_1234);
    check("dbz_const_lo", last_lo, 32'hFFFF_FFFF);

    // Cancel mid-RUN, with an ignored start pulse while busy
    prev_hi = last_hi;
    prev_lo = last_lo;
    done_before = n_done;
    issue(1'b0, 1'b0, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op_div = 1'b1;
    bus.operand_a = 32'd9; bus.operand_b = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (5) @(negedge clk);
    bus.cancel = 1'b1;
    @(posedge clk);
    #1;
    bus.cancel = 1'b0;
    void'(exp_q.pop_back());
    check("cancel_busy", W'(bus.busy), '0);
    repeat (40) @(negedge clk);
    check("cancel_no_done", W'(n_done - done_before), '0);
    check("cancel_hold_hi", bus.hi, prev_hi);
    check("cancel_hold_lo", bus.lo, prev_lo);

    // Reset mid-RUN, then a normal operation
    issue(1'b0, 1'b0, 32'hCAFE_0001, 32'h0000_0003, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    void'(exp_q.pop_back());
    check("rst_mid_hi", bus.hi, '0);
    check("rst_mid_lo", bus.lo, '0);
    check("rst_mid_busy", W'(bus.busy), '0);
    check("rst_mid_done", W'(bus.done), '0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 1'b0, 32'd1000, 32'd33, 1'b0);
    count_busy(n);
    check("post_rst_lo", last_lo, 32'd30);
    check("post_rst_hi", last_hi, 32'd10);

    // Randomized traffic
    for (int i = 0; i < 60; i++) begin
      issue(1'(($urandom >> 3) & 1), 1'(($urandom >> 5) & 1), pick(), pick(), 1'b0);
    end
    count_busy(n);
    repeat (3) @(negedge clk);
    check("queue_drained", W'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
